// File: rtl/fa_pkg.sv
// Shared definitions for the multi-precision add sequencer and its adder integration.
package fa_pkg;

   localparam int FA_N      = 8;
   localparam int FA_CHUNKS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fa_state_e;

   // Chunk index width; a single-chunk configuration still needs one bit.
   function automatic int fa_idx_width(input int chunks);
      return (chunks <= 1) ? 1 : $clog2(chunks);
   endfunction

endpackage

// File: rtl/fa_chunk_sequencer_if.sv
// Operand, adder and result signals of the chunk sequencer.
// master is the sequencer side; slave is the surrounding environment (source, adder, sink).
interface fa_chunk_sequencer_if #(
   parameter int N      = fa_pkg::FA_N,
   parameter int CHUNKS = fa_pkg::FA_CHUNKS
);

   logic                  in_valid;
   logic                  in_ready;
   logic [N*CHUNKS-1:0]   in_a;
   logic [N*CHUNKS-1:0]   in_b;
   logic                  in_cin;
   logic [N-1:0]          add_a;
   logic [N-1:0]          add_b;
   logic                  add_cin;
   logic [N-1:0]          add_sum;
   logic                  add_cout;
   logic                  out_valid;
   logic                  out_ready;
   logic [N*CHUNKS-1:0]   out_sum;
   logic                  out_cout;
   logic                  busy;

   modport master (
      input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
      output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
   );

   modport slave (
      output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
      input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
   );

endinterface

// File: rtl/fa_chunk_sequencer.sv
// Multi-precision add sequencer: walks a wide operand pair through an external
// N-bit adder one chunk per cycle (LSB first), chaining the carry, and presents
// the assembled wide sum on a valid/ready output.
module fa_chunk_sequencer
   import fa_pkg::*;
#(
   parameter int N      = FA_N,
   parameter int CHUNKS = FA_CHUNKS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fa_chunk_sequencer_if.master bus
);

   localparam int W  = N * CHUNKS;
   localparam int IW = fa_idx_width(CHUNKS);
   localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

   fa_state_e      state;
   fa_state_e      next_state;
   logic [IW-1:0]  idx;
   logic           carry;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic [W-1:0]   work_reg;
   logic [W-1:0]   sum_reg;
   logic           cout_reg;

   logic [31:0]    base;
   logic [W-1:0]   work_next;
   logic           last_chunk;
   logic           accept;
   logic           in_ready_c;
   logic [N-1:0]   add_a_c;
   logic [N-1:0]   add_b_c;
   logic           add_cin_c;
   logic           out_valid_c;
   logic           busy_c;

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and handshake/adder drive; adder inputs are zero outside RUN.
   always_comb begin
      next_state  = state;
      in_ready_c  = 1'b0;
      add_a_c     = '0;
      add_b_c     = '0;
      add_cin_c   = 1'b0;
      out_valid_c = 1'b0;
      busy_c      = 1'b0;
      base        = 32'(idx) * 32'(N);
      last_chunk  = (idx == LAST_IDX);
      case (state)
         IDLE: begin
            in_ready_c = rst_n;
            if (bus.in_valid && rst_n) begin
               next_state = RUN;
            end
         end
         RUN: begin
            busy_c    = 1'b1;
            add_a_c   = a_reg[base +: N];
            add_b_c   = b_reg[base +: N];
            add_cin_c = carry;
            if (last_chunk) begin
               next_state = DONE;
            end
         end
         DONE: begin
            busy_c      = 1'b1;
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      accept = in_ready_c && bus.in_valid;
   end

   // Merge the current adder sum into the partial result; only consumed in RUN.
   always_comb begin
      work_next              = work_reg;
      work_next[base +: N]   = bus.add_sum;
   end

   // Operand capture, carry chaining and result assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         carry    <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         work_reg <= '0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
      end else if (accept) begin
         a_reg <= bus.in_a;
         b_reg <= bus.in_b;
         carry <= bus.in_cin;
         idx   <= '0;
      end else if (state == RUN) begin
         work_reg <= work_next;
         carry    <= bus.add_cout;
         if (last_chunk) begin
            idx      <= '0;
            sum_reg  <= work_next;
            cout_reg <= bus.add_cout;
         end else begin
            idx <= idx + IW'(1);
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.add_a     = add_a_c;
   assign bus.add_b     = add_b_c;
   assign bus.add_cin   = add_cin_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_sum   = sum_reg;
   assign bus.out_cout  = cout_reg;
   assign bus.busy      = busy_c;

endmodule

// File: tb/tb_fa_chunk_sequencer.sv
// Self-checking bench for fa_chunk_sequencer: a behavioural N-bit adder closes the
// loop, expected wide sums are queued at acceptance and compared when results emerge.
module tb_fa_chunk_sequencer;

   localparam int N      = 8;
   localparam int CHUNKS = 4;
   localparam int W      = N * CHUNKS;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   assert_count = 0;
   int   fail_count = 0;
   exp_t sb_q[$];

   fa_chunk_sequencer_if #(.N(N), .CHUNKS(CHUNKS)) bus();
   fa_chunk_sequencer_if #(.N(N), .CHUNKS(1))      bus1();

   fa_chunk_sequencer #(.N(N), .CHUNKS(CHUNKS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   fa_chunk_sequencer #(.N(N), .CHUNKS(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Behavioural combinational adders standing in for the external n-bit adder.
   assign {bus.add_cout, bus.add_sum}   = {1'b0, bus.add_a} + {1'b0, bus.add_b} + (N+1)'(bus.add_cin);
   assign {bus1.add_cout, bus1.add_sum} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + (N+1)'(bus1.add_cin);

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Result monitor: every completed output handshake is checked against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         checkOutput("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("out_sum", 64'(bus.out_sum), 64'(e.sum));
            checkOutput("out_cout", 64'(bus.out_cout), 64'(e.cout));
         end
      end
   end

   // Called at a negedge; waits (bounded) for in_ready, then presents one operand pair.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, output int waited);
      logic [W:0] t;
      exp_t       e;
      waited = 0;
      while (!bus.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) checkOutput("in_ready_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      t      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      e.sum  = t[W-1:0];
      e.cout = t[W];
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // One full operation with per-chunk adder checks; optionally pokes in_valid mid-RUN.
   task automatic runAndCheck(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                              input bit inject, output int waited);
      logic [63:0] mask;
      logic [63:0] lowsum;
      logic [W-1:0] av;
      logic [W-1:0] bv;
      av = a;
      bv = b;
      applyStimulus(a, b, cin, waited);
      for (int k = 0; k < CHUNKS; k++) begin
         @(negedge clk);
         if (inject && k == 1) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'hDEADBEEF;
            bus.in_b     = 32'h0BADF00D;
            bus.in_cin   = 1'b1;
         end
         if (inject && k == 3) bus.in_valid = 1'b0;
         mask   = (64'd1 << (N*k)) - 64'd1;
         lowsum = ((64'(av) & mask) + (64'(bv) & mask) + 64'(cin)) >> (N*k);
         checkOutput($sformatf("add_a[%0d]", k), 64'(bus.add_a), 64'(av[N*k +: N]));
         checkOutput($sformatf("add_b[%0d]", k), 64'(bus.add_b), 64'(bv[N*k +: N]));
         checkOutput($sformatf("add_cin[%0d]", k), 64'(bus.add_cin), 64'(lowsum[0]));
         checkOutput($sformatf("run_in_ready[%0d]", k), 64'(bus.in_ready), 64'd0);
         checkOutput($sformatf("run_out_valid[%0d]", k), 64'(bus.out_valid), 64'd0);
      end
      @(negedge clk);
      checkOutput("out_valid_at_chunks_plus_1", 64'(bus.out_valid), 64'd1);
      checkOutput("done_busy", 64'(bus.busy), 64'd1);
      checkOutput("done_add_a_zero", 64'(bus.add_a), 64'd0);
   endtask

   initial begin
      int          waited;
      logic [N:0]  e1;
      bus.in_valid   = 1'b0;
      bus.in_a       = '0;
      bus.in_b       = '0;
      bus.in_cin     = 1'b0;
      bus.out_ready  = 1'b1;
      bus1.in_valid  = 1'b0;
      bus1.in_a      = '0;
      bus1.in_b      = '0;
      bus1.in_cin    = 1'b0;
      bus1.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_out_sum", 64'(bus.out_sum), 64'd0);
      checkOutput("rst_out_cout", 64'(bus.out_cout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("idle_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("idle_add_a", 64'(bus.add_a), 64'd0);
      @(negedge clk);

      // Single-chunk configuration behaves as a registered adder
      bus1.in_valid = 1'b1;
      bus1.in_a     = 8'hC8;
      bus1.in_b     = 8'h64;
      bus1.in_cin   = 1'b1;
      e1 = 9'h0C8 + 9'h064 + 9'h001;
      @(posedge clk);
      #1;
      bus1.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("c1_run_add_a", 64'(bus1.add_a), 64'hC8);
      checkOutput("c1_run_add_cin", 64'(bus1.add_cin), 64'd1);
      checkOutput("c1_run_out_valid", 64'(bus1.out_valid), 64'd0);
      @(negedge clk);
      checkOutput("c1_out_valid", 64'(bus1.out_valid), 64'd1);
      checkOutput("c1_out_sum", 64'(bus1.out_sum), 64'(e1[N-1:0]));
      checkOutput("c1_out_cout", 64'(bus1.out_cout), 64'(e1[N]));
      @(negedge clk);
      checkOutput("c1_back_idle", 64'(bus1.in_ready), 64'd1);

      // Basic carry, full ripple, mixed data
      runAndCheck(32'h000000FF, 32'h00000001, 1'b0, 1'b0, waited);
      runAndCheck(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, waited);
      runAndCheck(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, waited);

      // Backpressure: result held for three cycles, then earliest next accept
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      runAndCheck(32'h80000000, 32'h80000001, 1'b0, 1'b0, waited);
      for (int j = 0; j < 3; j++) begin
         if (j > 0) @(negedge clk);
         checkOutput($sformatf("bp_sum[%0d]", j), 64'(bus.out_sum), 64'h00000001);
         checkOutput($sformatf("bp_cout[%0d]", j), 64'(bus.out_cout), 64'd1);
         checkOutput($sformatf("bp_in_ready[%0d]", j), 64'(bus.in_ready), 64'd0);
         checkOutput($sformatf("bp_busy[%0d]", j), 64'(bus.busy), 64'd1);
         checkOutput($sformatf("bp_out_valid[%0d]", j), 64'(bus.out_valid), 64'd1);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("post_hs_sum_held", 64'(bus.out_sum), 64'h00000001);
      runAndCheck(32'h0F0F0F0F, 32'h10101010, 1'b1, 1'b0, waited);
      checkOutput("earliest_accept_wait", 64'(waited), 64'd0);

      // Busy ignore: in_valid during RUN must not start a second operation
      runAndCheck(32'h11111111, 32'h22222222, 1'b0, 1'b1, waited);

      // Reset during the second RUN cycle aborts the operation
      @(negedge clk);
      applyStimulus(32'h0000FFFF, 32'h00000001, 1'b0, waited);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("mid_rst_add_a", 64'(bus.add_a), 64'd0);
      checkOutput("mid_rst_add_cin", 64'(bus.add_cin), 64'd0);
      checkOutput("mid_rst_out_sum", 64'(bus.out_sum), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("post_rst_busy", 64'(bus.busy), 64'd0);
      runAndCheck(32'h01020304, 32'h10203040, 1'b1, 1'b0, waited);

      repeat (6) @(negedge clk);
      checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
      checkOutput("final_idle", 64'(bus.in_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
